turbo_rx_deframer: RTL and testbench
====================================

Name: turbo_rx_deframer

Overview:
- Receive-side counterpart of the turbo encoder control FSM.
- Accepts the encoder output stream as triples (systematic, parity1, parity2), one triple per accepted cycle.
- Separates each block into K data triples followed by 4 trellis-termination (tail) triples, and writes both, with addresses, into the decoder input buffers.
- Signals block completion to the downstream turbo decoder.

Parameters:
- LEN_LONG, 6, block length K when length_flag=1 (short value used for test builds).
- LEN_SHORT, 4, block length K when length_flag=0.
- CNT_W, 14, width of the position counter and out_addr.
- TAIL_LEN, 4, number of tail triples per block.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input triple present this cycle
- in_ready  out  1  block can accept a triple; transfer occurs when in_valid & in_ready
- in_sys  in  1  systematic bit
- in_p1  in  1  parity bit from constituent encoder 1
- in_p2  in  1  parity bit from constituent encoder 2
- length_flag  in  1  block size select, sampled only at block start
- out_valid  out  1  data triple written this cycle
- out_sys / out_p1 / out_p2  out  1 each  registered data triple
- out_addr  out  CNT_W  index 0..K-1 of the data triple, or 0..3 of the tail triple
- tail_valid  out  1  tail triple written this cycle; shares out_sys/out_p1/out_p2/out_addr
- block_done  out  1  one-cycle pulse after the last tail triple is written
- cur_len  out  CNT_W  latched K of the block in progress
- state  out  2  current state, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, cur_len=0.
  - All outputs 0, including in_ready.
  - Reset mid-block abandons the block: no block_done, and the partial buffer contents are ignored downstream.
- States and encodings: IDLE=0, DATA=1, TAIL=2, DONE=3.
- IDLE:
  - in_ready=1.
  - On the first accepted triple: latch cur_len = length_flag ? LEN_LONG : LEN_SHORT.
  - Emit that triple as data with out_addr=0, set counter=1, go to DATA.
  - If K==1, go straight to TAIL instead.
- DATA:
  - in_ready=1.
  - Each accepted triple: out_valid=1, out_addr=counter, counter+1.
  - When the accepted triple has counter==cur_len-1: reset counter to 0, go to TAIL.
  - in_valid=0: stall. Counter holds, out_valid=0; no timeout.
- TAIL:
  - in_ready=1.
  - Each accepted triple: tail_valid=1, out_valid=0, out_addr=counter (0..3).
  - When the triple with counter==TAIL_LEN-1 is accepted: go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - block_done=1 and in_ready=0 in that cycle; any in_valid is not accepted.
  - Counter is cleared and the block returns to IDLE.
  - Back-to-back blocks therefore have exactly one bubble cycle.
- Output timing:
  - Latency is 1 cycle from accepted input to out_valid/tail_valid.
  - out_sys/out_p1/out_p2/out_addr are registered and hold their values when not valid.
  - in_ready is combinational from state only; it never depends on in_valid.
- length_flag changes mid-block have no effect; cur_len holds until the next IDLE accept.
- out_valid and tail_valid are never high in the same cycle.
- Arithmetic:
  - The counter is unsigned CNT_W bits.
  - Comparisons use cur_len-1 computed at CNT_W width.
  - K is always at least 1, so no wrap-around can occur.

Decomposition:
- Shared package turbo_pkg holds:
  - state encodings (shared with the encoder control FSM where the values coincide),
  - TAIL_LEN=4,
  - default LEN_LONG/LEN_SHORT,
  - CNT_W.
- One natural sub-module: turbo_rx_pos_counter.
  - Loadable, enabled position counter with a terminal-count compare against a runtime limit.
  - Instantiated once; the limit is muxed between cur_len and TAIL_LEN by state.

Test Plan:
- Short block:
  - Stimulus: length_flag=0, in_valid held high for 8 cycles with data triples 0..3 then tail triples 0..3.
  - Required response: out_valid on 4 cycles with addr 0,1,2,3; tail_valid on 4 cycles with addr 0..3; block_done pulse on the cycle after the last tail triple; in_ready=0 in that cycle.
- Long block with stall:
  - Stimulus: length_flag=1, in_valid dropped for 3 cycles after data triple 2.
  - Required response: no outputs during the stall; addresses resume at 3 and reach 5; 4 tails follow; block_done asserted once.
- Mid-block flag toggle:
  - Stimulus: length_flag toggled to 0 during a long block.
  - Required response: cur_len stays 6; 6 data triples are still emitted.
- Back-to-back blocks:
  - Stimulus: in_valid held continuously across two blocks.
  - Required response: exactly one non-accepting cycle between blocks; the second block starts at addr 0.
- Reset mid-DATA:
  - Stimulus: assert reset asynchronously (off clock edge) after data triple 2.
  - Required response: all outputs 0 immediately; state=IDLE; no block_done; the next block starts at addr 0.
- Data integrity:
  - Stimulus: random triples over 50 blocks of mixed length.
  - Required response: the scoreboard matches every emitted triple and address one cycle after acceptance; out_valid and tail_valid are never high together.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared constants and state encodings for the turbo encoder/decoder datapath.
// Encoder control and receive deframer use the same state values.
package turbo_pkg;

    localparam int TURBO_CNT_W     = 14;
    localparam int TURBO_TAIL_LEN  = 4;
    localparam int TURBO_LEN_LONG  = 6;
    localparam int TURBO_LEN_SHORT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } turbo_state_t;

    // Block length K selected by the length flag at block start.
    function automatic int block_len(input logic length_flag,
                                     input int   len_long,
                                     input int   len_short);
        if (length_flag) begin
            return len_long;
        end else begin
            return len_short;
        end
    endfunction

endpackage

// File: rtl/turbo_rx_deframer_if.sv
// Input triple stream into the deframer: valid/ready handshake plus the
// systematic/parity bits and the per-block length select.
interface turbo_rx_deframer_if;
    import turbo_pkg::*;

    logic in_valid;
    logic in_ready;
    logic in_sys;
    logic in_p1;
    logic in_p2;
    logic length_flag;

    modport master (
        output in_valid,
        output in_sys,
        output in_p1,
        output in_p2,
        output length_flag,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sys,
        input  in_p1,
        input  in_p2,
        input  length_flag,
        output in_ready
    );

endinterface

// File: rtl/turbo_rx_pos_counter.sv
// Loadable, enabled position counter; term flags the last position before
// a runtime limit (count == limit-1).
module turbo_rx_pos_counter #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         term
);

    localparam logic [W-1:0] ONE = W'(1);

    // Position register: load has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

    // Limit is always >= 1, so limit-1 never wraps.
    always_comb begin
        term = (count == (limit - ONE));
    end

endmodule

// File: rtl/turbo_rx_deframer.sv
// Receive deframer: splits each encoded block into K data triples and
// TAIL_LEN termination triples, addressing both into the decoder buffers.
module turbo_rx_deframer
    import turbo_pkg::*;
#(
    parameter int LEN_LONG  = TURBO_LEN_LONG,
    parameter int LEN_SHORT = TURBO_LEN_SHORT,
    parameter int CNT_W     = TURBO_CNT_W,
    parameter int TAIL_LEN  = TURBO_TAIL_LEN
) (
    input  logic               clk,
    input  logic               reset,
    turbo_rx_deframer_if.slave bus,
    output logic               out_valid,
    output logic               out_sys,
    output logic               out_p1,
    output logic               out_p2,
    output logic [CNT_W-1:0]   out_addr,
    output logic               tail_valid,
    output logic               block_done,
    output logic [CNT_W-1:0]   cur_len,
    output logic [1:0]         state
);

    turbo_state_t     state_r;
    turbo_state_t     state_nxt_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [CNT_W-1:0] k_new_s;
    logic             k_one_s;
    logic [CNT_W-1:0] limit_s;
    logic [CNT_W-1:0] count_s;
    logic             term_s;
    logic             cnt_load_s;
    logic             cnt_en_s;
    logic [CNT_W-1:0] cnt_val_s;

    assign accept_s     = bus.in_valid & in_ready_s;
    assign bus.in_ready = in_ready_s;
    assign state        = state_r;

    // Candidate K for a new block and the terminal-count limit per phase.
    always_comb begin
        k_new_s = CNT_W'(block_len(bus.length_flag, LEN_LONG, LEN_SHORT));
        k_one_s = (k_new_s == CNT_W'(1));
        if (state_r == ST_TAIL) begin
            limit_s = CNT_W'(TAIL_LEN);
        end else begin
            limit_s = cur_len;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = k_one_s ? ST_TAIL : ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept_s && term_s) begin
                    state_nxt_s = ST_TAIL;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_TAIL: begin
                if (accept_s && term_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_TAIL;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output: ready depends on state only (and is held low in reset).
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA, ST_TAIL: begin
                in_ready_s = ~reset;
            end
            ST_DONE: begin
                in_ready_s = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // Position counter control: K==1 skips straight to tail position 0.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        cnt_val_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = k_one_s ? '0 : CNT_W'(1);
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_DATA, ST_TAIL: begin
                if (accept_s && term_s) begin
                    cnt_load_s = 1'b1;
                end else if (accept_s) begin
                    cnt_en_s = 1'b1;
                end else begin
                    cnt_en_s = 1'b0;
                end
            end
            ST_DONE: begin
                cnt_load_s = 1'b1;
            end
            default: begin
                cnt_load_s = 1'b1;
            end
        endcase
    end

    turbo_rx_pos_counter #(
        .W (CNT_W)
    ) u_pos (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .en       (cnt_en_s),
        .limit    (limit_s),
        .count    (count_s),
        .term     (term_s)
    );

    // Registered output stage, one cycle after acceptance; fields hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            tail_valid <= 1'b0;
            block_done <= 1'b0;
            out_sys    <= 1'b0;
            out_p1     <= 1'b0;
            out_p2     <= 1'b0;
            out_addr   <= '0;
            cur_len    <= '0;
        end else begin
            out_valid  <= accept_s & ((state_r == ST_IDLE) | (state_r == ST_DATA));
            tail_valid <= accept_s & (state_r == ST_TAIL);
            block_done <= accept_s & (state_r == ST_TAIL) & term_s;
            if (accept_s) begin
                out_sys  <= bus.in_sys;
                out_p1   <= bus.in_p1;
                out_p2   <= bus.in_p2;
                out_addr <= (state_r == ST_IDLE) ? '0 : count_s;
            end else begin
                out_sys  <= out_sys;
                out_p1   <= out_p1;
                out_p2   <= out_p2;
                out_addr <= out_addr;
            end
            if (accept_s && (state_r == ST_IDLE)) begin
                cur_len <= k_new_s;
            end else begin
                cur_len <= cur_len;
            end
        end
    end

endmodule

// File: tb/tb_turbo_rx_deframer.sv
// Directed bench for turbo_rx_deframer: hand-computed vectors for short,
// stalled, toggled, back-to-back, reset and random mixed-length blocks.
module tb_turbo_rx_deframer;

    logic        clk;
    logic        reset;
    logic        out_valid;
    logic        out_sys;
    logic        out_p1;
    logic        out_p2;
    logic [13:0] out_addr;
    logic        tail_valid;
    logic        block_done;
    logic [13:0] cur_len;
    logic [1:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    turbo_rx_deframer_if bus ();

    turbo_rx_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .out_valid  (out_valid),
        .out_sys    (out_sys),
        .out_p1     (out_p1),
        .out_p2     (out_p2),
        .out_addr   (out_addr),
        .tail_valid (tail_valid),
        .block_done (block_done),
        .cur_len    (cur_len),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive a triple, check ready/state before the edge, outputs after.
    task automatic xfer(input logic v, input logic [2:0] d, input logic lf,
                        input logic e_rdy, input logic [1:0] e_st,
                        input logic e_ov, input logic e_tv,
                        input logic [13:0] e_addr, input logic e_bd);
        bus.in_valid    = v;
        bus.in_sys      = d[2];
        bus.in_p1       = d[1];
        bus.in_p2       = d[0];
        bus.length_flag = lf;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_rdy});
        chk("state", {30'd0, state}, {30'd0, e_st});
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
        chk("tail_valid", {31'd0, tail_valid}, {31'd0, e_tv});
        chk("block_done", {31'd0, block_done}, {31'd0, e_bd});
        chk("valid_exclusive", {31'd0, out_valid & tail_valid}, 32'd0);
        if (e_ov || e_tv) begin
            chk("out_addr", {18'd0, out_addr}, {18'd0, e_addr});
            chk("out_triple", {29'd0, out_sys, out_p1, out_p2}, {29'd0, d});
        end
    endtask

    task automatic maybe_stall(input bit stall, input logic lf, input logic [1:0] st);
        if (stall && ($urandom_range(0, 3) == 0)) begin
            xfer(1'b0, 3'b000, lf, 1'b1, st, 1'b0, 1'b0, 14'd0, 1'b0);
        end
    endtask

    // Full block of k data triples, 4 tails and the DONE bubble (with in_valid high).
    task automatic run_block(input int k, input logic lf0, input logic lf1, input bit stall);
        logic [2:0] d;
        for (int i = 0; i < k; i++) begin
            maybe_stall(stall, (i == 0) ? lf0 : lf1, (i == 0) ? 2'd0 : 2'd1);
            d = 3'($urandom_range(0, 7));
            xfer(1'b1, d, (i == 0) ? lf0 : lf1, 1'b1, (i == 0) ? 2'd0 : 2'd1,
                 1'b1, 1'b0, 14'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            maybe_stall(stall, lf1, 2'd2);
            d = 3'($urandom_range(0, 7));
            xfer(1'b1, d, lf1, 1'b1, 2'd2, 1'b0, 1'b1, 14'(i), (i == 3) ? 1'b1 : 1'b0);
        end
        chk("cur_len_block", {18'd0, cur_len}, 32'(k));
        xfer(1'b1, 3'b111, lf1, 1'b0, 2'd3, 1'b0, 1'b0, 14'd0, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sys      = 1'b0;
        bus.in_p1       = 1'b0;
        bus.in_p2       = 1'b0;
        bus.length_flag = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_outputs", {29'd0, out_valid, tail_valid, block_done}, 32'd0);
        chk("reset_cur_len", {18'd0, cur_len}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Short block: K=4, data 0..3 then tails 0..3, then the DONE bubble.
        xfer(1'b1, 3'b101, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 14'd0, 1'b0);
        chk("short_cur_len", {18'd0, cur_len}, 32'd4);
        xfer(1'b1, 3'b010, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 14'd1, 1'b0);
        xfer(1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 14'd2, 1'b0);
        xfer(1'b1, 3'b001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 14'd3, 1'b0);
        xfer(1'b1, 3'b110, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 14'd0, 1'b0);
        xfer(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 14'd1, 1'b0);
        xfer(1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 14'd2, 1'b0);
        xfer(1'b1, 3'b100, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 14'd3, 1'b1);
        xfer(1'b1, 3'b101, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 14'd0, 1'b0);

        // Long block, K=6, with a three-cycle stall after data triple 2.
        xfer(1'b1, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 14'd0, 1'b0);
        xfer(1'b1, 3'b100, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd1, 1'b0);
        xfer(1'b1, 3'b110, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd2, 1'b0);
        xfer(1'b0, 3'b001, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 14'd0, 1'b0);
        xfer(1'b0, 3'b001, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 14'd0, 1'b0);
        xfer(1'b0, 3'b001, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 14'd0, 1'b0);
        chk("stall_addr_hold", {18'd0, out_addr}, 32'd2);
        chk("stall_triple_hold", {29'd0, out_sys, out_p1, out_p2}, 32'd6);
        xfer(1'b1, 3'b001, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd3, 1'b0);
        xfer(1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd4, 1'b0);
        xfer(1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd5, 1'b0);
        xfer(1'b1, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 14'd0, 1'b0);
        xfer(1'b1, 3'b101, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 14'd1, 1'b0);
        xfer(1'b1, 3'b011, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 14'd2, 1'b0);
        xfer(1'b1, 3'b110, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 14'd3, 1'b1);
        chk("long_cur_len", {18'd0, cur_len}, 32'd6);
        xfer(1'b0, 3'b000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 14'd0, 1'b0);

        // Mid-block length_flag toggle: K stays 6.
        run_block(6, 1'b1, 1'b0, 1'b0);

        // Back-to-back blocks with in_valid held high across the DONE bubble.
        run_block(4, 1'b0, 1'b0, 1'b0);
        run_block(6, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-DATA after data triple 2.
        xfer(1'b1, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 14'd0, 1'b0);
        xfer(1'b1, 3'b101, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd1, 1'b0);
        xfer(1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 14'd2, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {29'd0, out_valid, tail_valid, block_done}, 32'd0);
        chk("rst_mid_triple", {29'd0, out_sys, out_p1, out_p2}, 32'd0);
        chk("rst_mid_addr", {18'd0, out_addr}, 32'd0);
        chk("rst_mid_cur_len", {18'd0, cur_len}, 32'd0);
        chk("rst_mid_state", {30'd0, state}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_block(4, 1'b0, 1'b1, 1'b0);

        // Random triples over 50 mixed-length blocks with random stalls.
        for (int b = 0; b < 50; b++) begin
            logic lf;
            lf = 1'($urandom_range(0, 1));
            run_block(lf ? 6 : 4, lf, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
